// File: rtl/mux_rr_sel.sv
// N-channel valid/ready selector with manual, fixed-priority and round-robin
// grant modes feeding a single registered output slot.
module mux_rr_sel #(
  parameter int unsigned NCH = 8,
  parameter int unsigned W = 8,
  localparam int unsigned SELW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH*W-1:0]  in_data,
  input  logic [NCH-1:0]    in_valid,
  output logic [NCH-1:0]    in_ready,
  input  logic [1:0]        mode,
  input  logic [SELW-1:0]   sel,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SELW-1:0]   out_ch
);

  localparam logic [1:0] MODE_MAN0 = 2'b00;
  localparam logic [1:0] MODE_FIX  = 2'b01;
  localparam logic [1:0] MODE_RR   = 2'b10;

  logic [SELW-1:0] rr_ptr;
  logic            grant_vld;
  logic [SELW-1:0] grant_idx;
  logic [W-1:0]    grant_data;
  logic            load_en;
  logic            xfer;

  // Grant search; manual uses a compare loop so sel >= NCH simply never matches.
  always_comb begin
    int unsigned idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    case (mode)
      MODE_FIX: begin
        for (int i = NCH - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
      MODE_RR: begin
        for (int unsigned off = 0; off < NCH; off++) begin
          idx = 32'(rr_ptr) + off;
          if (idx >= NCH) idx = idx - NCH;
          if (!grant_vld && in_valid[idx]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(idx);
          end
        end
      end
      default: begin
        for (int unsigned i = 0; i < NCH; i++) begin
          if (sel == SELW'(i) && in_valid[i]) begin
            grant_vld = 1'b1;
            grant_idx = SELW'(i);
          end
        end
      end
    endcase
  end

  // Data mux for the granted channel.
  always_comb begin
    grant_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (grant_idx == SELW'(i)) grant_data = in_data[i*W +: W];
    end
  end

  assign load_en = !out_valid || out_ready;
  assign xfer    = grant_vld && load_en;

  always_comb begin
    in_ready = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (xfer && grant_idx == SELW'(i)) in_ready[i] = 1'b1;
    end
  end

  // Output slot: load on transfer, drop valid on drain without refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant_idx;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Round-robin pointer advances past the winner only on RR transfers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (xfer && mode == MODE_RR) begin
      rr_ptr <= (32'(grant_idx) == NCH - 1) ? '0 : grant_idx + SELW'(1);
    end
  end

  logic unused_man0;
  assign unused_man0 = (MODE_MAN0 == 2'b00);

endmodule
